viterbi_tb_ctrl: RTL

Frame-based traceback controller for the 4-state (K=3) Viterbi decoder. Buffers per-symbol survivor decision bits from the ACS stage and latches the traceback start state from the minimum-path-cost finder. At frame end it walks the trellis backwards, then streams the decoded bits out in forward order over a valid/ready handshake. Sits between the ACS/min-state logic and the decoded-bit sink.

---
 rtl/viterbi_tb_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/viterbi_tb_ctrl.sv
// viterbi_tb_ctrl: frame-based traceback controller for a 4-state (K=3)
// Viterbi decoder. Survivor decision words are buffered per symbol. At
// frame end the trellis is walked backwards one step per cycle. The decoded
// bits are then streamed out in forward order.
//
// Optional feature macro: VITERBI_TB_ZERO_TAIL_EN
//   defined   -> trellis is terminated, traceback starts from state 2'b00
//   undefined -> traceback starts from start_state latched with last symbol
//
// Handshake semantics (both ports): a transfer happens on a rising clk edge
// where valid & ready are both high. A source holds its data stable until
// that transfer. out_bit/out_last never change while out_valid=1 and
// out_ready=0. in_valid while in_ready=0 is ignored.
`timescale 1ns/1ps

module viterbi_tb_ctrl #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] dec_bits,
  input  logic       in_last,
  input  logic [1:0] start_state,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_bit,
  output logic       out_last,
  output logic       busy,
  output logic       ovf
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    TRACE  = 2'd2,
    OUTPUT = 2'd3
  } state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_t        state;
  state_t        state_nx;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] last_idx;   // n-1 of the current frame
  logic [AW-1:0] tr_idx;
  logic [AW-1:0] rd_ptr;
  logic [1:0]    tr_state;
  logic [1:0]    tb_start;

  logic [3:0]       mem [DEPTH];
  logic [DEPTH-1:0] bitbuf;

  logic accept;
  logic frame_end;
  logic truncate;
  logic [3:0] cur_word;

`ifdef VITERBI_TB_ZERO_TAIL_EN
  // Terminated trellis: start_state carries no information here.
  logic unused_start_state;
  assign unused_start_state = ^start_state;
  assign tb_start = 2'b00;
`else
  assign tb_start = start_state;
`endif

  assign accept    = in_valid & in_ready;
  assign truncate  = accept & ~in_last & (wr_ptr == LAST_ADDR);
  assign frame_end = accept & (in_last | (wr_ptr == LAST_ADDR));
  assign cur_word  = mem[tr_idx];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state decode and handshake/output decode.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_bit   = 1'b0;
    out_last  = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (accept) state_nx = frame_end ? TRACE : FILL;
      end
      FILL: begin
        in_ready = 1'b1;
        if (frame_end) state_nx = TRACE;
      end
      TRACE: begin
        if (tr_idx == '0) state_nx = OUTPUT;
      end
      OUTPUT: begin
        out_valid = 1'b1;
        out_bit   = bitbuf[rd_ptr];
        out_last  = (rd_ptr == last_idx);
        if (out_ready && out_last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Pointers, traceback state and sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      last_idx <= '0;
      tr_idx   <= '0;
      rd_ptr   <= '0;
      tr_state <= 2'b00;
      ovf      <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr <= frame_end ? '0 : wr_ptr + 1'b1;
        if (frame_end) begin
          last_idx <= wr_ptr;
          tr_idx   <= wr_ptr;
          tr_state <= tb_start;
        end
      end
      if (truncate) ovf <= 1'b1;
      if (state == TRACE) begin
        // Step to the predecessor: {s[0], survivor bit of s at this symbol}.
        tr_state <= {tr_state[0], cur_word[tr_state]};
        if (tr_idx == '0) rd_ptr <= '0;
        else              tr_idx <= tr_idx - 1'b1;
      end
      if (state == OUTPUT && out_ready) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Survivor buffer write; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= dec_bits;
  end

  // Decoded-bit buffer: the bit at step t is the MSB of the state at t.
  always_ff @(posedge clk) begin
    if (state == TRACE) bitbuf[tr_idx] <= tr_state[1];
  end

endmodule
